seq_counter_sched: RTL

Two-requester scheduler in front of the 8-bit sequence counter (start/skip-driven, home value 0, lap 7→…→13→7). It accepts lap jobs over valid/ready, grants the counter round-robin and drives the counter's start, skip and reset. It counts completed laps from the counter's output, then returns the counter to 0 and reports completion. It sits between client blocks and a single shared counter instance.

---
 rtl/seq_counter_sched_pkg.sv | 17 +
 rtl/seq_counter_sched_if.sv | 27 ++
 rtl/seq_counter_sched_rr_arb2.sv | 19 +
 rtl/seq_counter_sched.sv | 133 +++++++++++++
 4 files changed

// File: rtl/seq_counter_sched_pkg.sv
// Shared types and counter constants for the lap-job scheduler.
package seq_counter_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } sched_state_e;

  localparam logic [7:0] SEQ_HOME     = 8'd0;
  localparam logic [7:0] SEQ_FIRST    = 8'd7;
  localparam logic [7:0] SEQ_LAST     = 8'd13;
  localparam int         LAP_LEN_NORM = 7;
  localparam int         LAP_LEN_SKIP = 4;

endpackage

// File: rtl/seq_counter_sched_if.sv
// Client request/completion bundle plus the control lines of the shared sequence counter.
interface seq_counter_sched_if #(
  parameter int LAP_W = 4
);
  logic [1:0]         req_valid;
  logic [2*LAP_W-1:0] req_laps;
  logic [1:0]         req_skip;
  logic [1:0]         req_ready;
  logic [1:0]         done_pulse;
  logic               done_err;
  logic               busy;
  logic               grant_id;
  logic               seq_start;
  logic               seq_skip;
  logic               seq_rstn;
  logic [7:0]         seq_count;

  modport master (
    output req_valid, req_laps, req_skip, seq_count,
    input  req_ready, done_pulse, done_err, busy, grant_id, seq_start, seq_skip, seq_rstn
  );

  modport slave (
    input  req_valid, req_laps, req_skip, seq_count,
    output req_ready, done_pulse, done_err, busy, grant_id, seq_start, seq_skip, seq_rstn
  );
endinterface

// File: rtl/seq_counter_sched_rr_arb2.sv
// Two-way round-robin arbiter; the last-grant register only moves when a grant is accepted.
module seq_counter_sched_rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);
  logic r_last;

  // Reset to "requester 1 went last" so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_last <= 1'b1;
    else if (i_accept) r_last <= o_gnt[1];
  end

  assign o_gnt[0] = i_req[0] & (~i_req[1] | r_last);
  assign o_gnt[1] = i_req[1] & (~i_req[0] | ~r_last);
endmodule

// File: rtl/seq_counter_sched.sv
// Round-robin lap-job scheduler driving a shared external start/skip sequence counter.
module seq_counter_sched
  import seq_counter_sched_pkg::*;
#(
  parameter int LAP_W   = 4,
  parameter int TIMEOUT = 16
) (
  input logic                clk,
  input logic                rstn,
  seq_counter_sched_if.slave sched_bus
);
  // state  | meaning
  // IDLE   | waiting for a request, arbiter grant shown on req_ready
  // LAUNCH | start asserted until the counter reaches 7
  // RUN    | counting laps in the job's skip mode
  // DONE   | counter held in reset, completion strobe
  localparam int               TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_INIT = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [LAP_W-1:0] LAP_ONE  = LAP_W'(1);

  sched_state_e     r_state, w_next;
  logic [LAP_W-1:0] r_laps, r_laps_done, w_req_laps;
  logic [TMO_W-1:0] r_tmo;
  logic [7:0]       r_prev_cnt;
  logic             r_skip, r_grant_id, r_err, r_seq_rstn;
  logic [1:0]       w_gnt;
  logic             w_accept, w_win, w_lap_evt, w_entry7, w_tmo_hit, w_to_err;

  seq_counter_sched_rr_arb2 u_arb (
    .clk      (clk),
    .rstn     (rstn),
    .i_req    (sched_bus.req_valid),
    .i_accept (w_accept),
    .o_gnt    (w_gnt)
  );

  assign w_accept   = (r_state == IDLE) && (sched_bus.req_valid != 2'b00);
  assign w_win      = w_gnt[1];
  assign w_req_laps = w_win ? sched_bus.req_laps[2*LAP_W-1:LAP_W] : sched_bus.req_laps[LAP_W-1:0];
  assign w_lap_evt  = (sched_bus.seq_count == SEQ_FIRST) && (r_prev_cnt == SEQ_LAST);
  assign w_entry7   = (sched_bus.seq_count == SEQ_FIRST) && (r_prev_cnt != SEQ_FIRST);
  assign w_tmo_hit  = (r_tmo == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_to_err = 1'b0;
    unique case (r_state)
      IDLE:   if (w_accept) w_next = (w_req_laps == '0) ? DONE : LAUNCH;
      LAUNCH: begin
        if (sched_bus.seq_count == SEQ_FIRST) w_next = RUN;
        else if (w_tmo_hit) begin
          w_next   = DONE;
          w_to_err = 1'b1;
        end
      end
      RUN: begin
        if (w_lap_evt && ((r_laps_done + LAP_ONE) == r_laps)) w_next = DONE;
        else if (!w_entry7 && w_tmo_hit) begin
          w_next   = DONE;
          w_to_err = 1'b1;
        end
      end
      DONE:   w_next = IDLE;
    endcase
  end

  // The timeout is a down-counter reloaded on accept, on RUN entry and on every fresh arrival at 7.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_laps      <= '0;
      r_laps_done <= '0;
      r_skip      <= 1'b0;
      r_grant_id  <= 1'b0;
      r_err       <= 1'b0;
      r_tmo       <= TMO_INIT;
      r_prev_cnt  <= SEQ_HOME;
      r_seq_rstn  <= 1'b0;
    end else begin
      r_prev_cnt <= sched_bus.seq_count;
      r_seq_rstn <= (w_next != DONE);
      if (w_accept) begin
        r_laps     <= w_req_laps;
        r_skip     <= sched_bus.req_skip[w_win];
        r_grant_id <= w_win;
        r_err      <= 1'b0;
        r_tmo      <= TMO_INIT;
      end else if (w_to_err) begin
        r_err <= 1'b1;
      end
      if (r_state == LAUNCH && w_next == RUN) begin
        r_laps_done <= '0;
        r_tmo       <= TMO_INIT;
      end else if (r_state == RUN && w_entry7) begin
        r_tmo <= TMO_INIT;
        if (w_lap_evt) r_laps_done <= r_laps_done + LAP_ONE;
      end else if ((r_state == LAUNCH || r_state == RUN) && !w_tmo_hit) begin
        r_tmo <= r_tmo - TMO_ONE;
      end
    end
  end

  // Skip follows the job already on the 7 that ends LAUNCH, so the first lap step uses the job's mode.
  always_comb begin
    sched_bus.req_ready  = 2'b00;
    sched_bus.done_pulse = 2'b00;
    sched_bus.done_err   = 1'b0;
    sched_bus.seq_start  = 1'b0;
    sched_bus.seq_skip   = 1'b0;
    case (r_state)
      IDLE:   if (rstn) sched_bus.req_ready = w_gnt;
      LAUNCH: begin
        sched_bus.seq_start = 1'b1;
        if (sched_bus.seq_count == SEQ_FIRST) sched_bus.seq_skip = r_skip;
      end
      RUN:    sched_bus.seq_skip = r_skip;
      DONE:   begin
        sched_bus.done_pulse[r_grant_id] = 1'b1;
        sched_bus.done_err               = r_err;
      end
      default: ;
    endcase
  end

  assign sched_bus.busy     = (r_state != IDLE);
  assign sched_bus.grant_id = r_grant_id;
  assign sched_bus.seq_rstn = r_seq_rstn;
endmodule
